substitute: RTL and testbench
=============================

# substitute

AES SubBytes stage for a 128-bit encryption datapath. Each of the 16 state bytes is replaced independently by its FIPS-197 forward S-box value, and the result is registered. The block sits between AddRoundKey and ShiftRows in the round pipeline and has no inter-byte mixing.

## Interface
- Parameters: none. The S-box is fixed, byte width is 8, and the state is 16 bytes.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  high for one cycle per state to be substituted.
- state  input  16x8 (packed [15:0][7:0], 128 bits)  input state bytes.
  - Byte i occupies bits [8i+7:8i].
  - Layout is column-major: bytes 0..3 form column 0, bytes 4..7 form column 1, and so on.
- newstate  output  16x8 (packed [15:0][7:0])  substituted state, same byte layout as state.
- out_valid  output  1  high for one cycle when newstate holds a freshly substituted state.

## Operation
- The substitution is combinational: sub[i] = SBOX(state[i]) for i = 0..15.
- SBOX is the 256-entry FIPS-197 forward table, implemented as a constant lookup (case statement or ROM).
  - Do not use the inverse S-box.
  - No affine or GF(2^8) inversion logic is required.
- Capture rule: on a rising clk edge with in_valid=1, newstate <= sub and out_valid <= 1.
- Hold rule: on a rising clk edge with in_valid=0, newstate holds its previous value and out_valid <= 0.
- There is no backpressure; every in_valid cycle is accepted.
- Back-to-back in_valid cycles are legal and produce back-to-back out_valid cycles.
- Bytes are fully independent: changing one input byte changes only the corresponding output byte.
- Required S-box spot values:
  - S(00)=63, S(01)=7c, S(53)=ed, S(ff)=16.
  - S(19)=d4, S(3d)=27, S(e3)=11, S(be)=ae.
  - S(a0)=e0, S(f4)=bf, S(e2)=98, S(2b)=f1.
  - S(9a)=b8, S(c6)=b4, S(8d)=5d, S(2a)=e5.
  - S(e9)=1e, S(f8)=41, S(48)=52, S(08)=30.
- No X propagation from the table: every 8-bit input value has a defined output, and no default-X branch is permitted.

## Timing
- Latency: 1 cycle. An input sampled at edge N appears on newstate, with out_valid=1, immediately after edge N.
- Throughput: one state per cycle.
- Reset behaviour:
  - Asserting rst_n=0 forces newstate=128'h0 and out_valid=0 immediately, independent of clk.
  - Reset asserted mid-stream discards the in-flight result.
  - The first capture after rst_n deasserts occurs on the first rising edge that sees in_valid=1.
- Changes on state while in_valid=0 must not alter newstate.
- The combinational path runs state to 16 parallel 8-bit lookups to the register. There is no path from input to output that bypasses the register.

## Test plan
- Reset: assert rst_n=0 with arbitrary state and in_valid toggling -> newstate=0 and out_valid=0 throughout; the values clear asynchronously, without waiting for a clock edge.
- FIPS-197 round-1 vector:
  - Stimulus: state bytes 0..15 = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, in_valid=1 for one cycle.
  - Required response, next cycle: out_valid=1 and newstate bytes 0..15 = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30.
  - Following cycle: out_valid=0 and newstate unchanged.
- Boundary bytes: all bytes 00 -> all bytes 63; all bytes ff -> all bytes 16; byte 0=53 with the rest 01 -> byte 0=ed, the rest 7c.
- Exhaustive table: apply each value v=00..ff to all 16 bytes in back-to-back in_valid cycles -> every output byte equals the FIPS-197 SBOX(v) one cycle later, and out_valid stays high continuously.
- Hold behaviour: after a capture, change state with in_valid=0 for 5 cycles -> newstate is stable and out_valid=0.
- Mid-stream reset: pulse rst_n low between two in_valid cycles -> output clears to 0; the next valid input produces the correct result one cycle later.

Source files
------------

// File: rtl/substitute.sv
// AES SubBytes stage: sixteen parallel forward S-box lookups feeding one output register.
// Reset clears the output state and the valid flag asynchronously.
module substitute (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0][7:0] state,
  output logic [15:0][7:0] newstate,
  output logic             out_valid
);

  // FIPS-197 forward S-box, entry n is S(n); every index has a defined value.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [15:0][7:0] sub_d;
  logic [15:0][7:0] newstate_q;
  logic             out_valid_q;

  always_comb begin
    sub_d = '0;
    for (int i = 0; i < 16; i++) begin
      sub_d[i] = SBOX[state[i]];
    end
  end

  // NOTE: state registers use non-blocking assignments and clear only through the async reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      newstate_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        newstate_q <= sub_d;
      end
    end
  end

  assign newstate  = newstate_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_substitute.sv
// Self-checking bench for substitute: expectations come from a GF(2^8) inverse + affine
// S-box model or literal FIPS-197 vectors, queued at drive time and popped after each edge.
module tb_substitute;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [15:0][7:0] state;
  logic [15:0][7:0] newstate;
  logic             out_valid;

  substitute dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .state     (state),
    .newstate  (newstate),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         v;
    logic [127:0] d;
  } exp_t;

  exp_t         sb[$];
  logic [7:0]   exp_tab [256];
  logic [127:0] model_ns;
  int           n_checks = 0;
  int           n_pass   = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S(x) = affine(x^254); x^254 is the multiplicative inverse, with 0 mapping to 0.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_model(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = exp_tab[s[8*k +: 8]];
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // Drive one cycle at the falling edge, queue the expectation, compare just after the rising edge.
  task automatic step(input string tag, input logic v, input logic [127:0] s, input logic [127:0] e);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    state    = s;
    if (v) model_ns = e;
    x.v = v;
    x.d = model_ns;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_queue"}, 128'd0, 128'd1);
    end else begin
      x = sb.pop_front();
      check({tag, "_valid"}, {127'd0, out_valid}, {127'd0, x.v});
      check({tag, "_data"}, newstate, x.d);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] s;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    state    = '0;
    model_ns = '0;
    for (int v = 0; v < 256; v++) exp_tab[v] = sbox_model(v[7:0]);

    // Held in reset with activity on the inputs: outputs stay cleared.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = k[0] ? 1'b0 : 1'b1;
      state    = rnd128();
      @(posedge clk);
      #1;
      check("reset_hold_valid", {127'd0, out_valid}, 128'd0);
      check("reset_hold_data", newstate, 128'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    step("idle_after_reset", 1'b0, rnd128(), '0);

    step("fips_round1", 1'b1, 128'h0848f8e92a8dc69a2be2f4a0bee33d19,
         128'h3052411ee55db4b8f198bfe0ae1127d4);
    step("fips_round1_after", 1'b0, 128'h0848f8e92a8dc69a2be2f4a0bee33d19, '0);

    step("all_00", 1'b1, {16{8'h00}}, {16{8'h63}});
    step("all_ff", 1'b1, {16{8'hff}}, {16{8'h16}});
    step("b0_53_rest_01", 1'b1, {{15{8'h01}}, 8'h53}, {{15{8'h7c}}, 8'hed});

    for (int v = 0; v < 256; v++) begin
      s = {16{v[7:0]}};
      step("exhaustive", 1'b1, s, {16{exp_tab[v]}});
    end

    for (int k = 0; k < 5; k++) step("hold", 1'b0, rnd128(), '0);

    // Asynchronous clear between edges, with no clock edge in between.
    s = rnd128();
    step("pre_async_reset", 1'b1, s, sub_model(s));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_valid", {127'd0, out_valid}, 128'd0);
    check("async_clear_data", newstate, 128'd0);
    model_ns = '0;

    // A valid input presented while in reset is discarded.
    @(negedge clk);
    in_valid = 1'b1;
    state    = rnd128();
    @(posedge clk);
    #1;
    check("in_flight_discard_valid", {127'd0, out_valid}, 128'd0);
    check("in_flight_discard_data", newstate, 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    s = rnd128();
    step("post_reset_capture", 1'b1, s, sub_model(s));
    s = rnd128();
    step("post_reset_b2b", 1'b1, s, sub_model(s));
    step("post_reset_idle", 1'b0, rnd128(), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
